// File: rtl/video_out_timing_if.sv
// Read-FIFO side of the video output path: pixel data and occupancy in, pop and fill-enable out.
// The timing generator is the master; the FIFO controller side is the slave.
interface video_out_timing_if;
    logic [15:0] fifo_dout;
    logic        fifo_empty;
    logic [9:0]  fifo_rd_count;
    logic        rd_en;
    logic        rd_valid;

    modport master (
        input  fifo_dout,
        input  fifo_empty,
        input  fifo_rd_count,
        output rd_en,
        output rd_valid
    );

    modport slave (
        output fifo_dout,
        output fifo_empty,
        output fifo_rd_count,
        input  rd_en,
        input  rd_valid
    );
endinterface

// File: rtl/video_out_timing.sv
// Raster timing generator that pulls RGB565 pixels from the SDRAM read FIFO in step with the raster.
// state | meaning
// IDLE  | waiting for SDRAM init; all outputs at reset values
// PRIME | FIFO filling enabled, waiting for occupancy to reach PRIME_LEVEL
// RUN   | raster counters running, pixels popped on every visible cycle
module video_out_timing #(
    parameter int H_ACTIVE    = 640,
    parameter int H_FP        = 16,
    parameter int H_SYNC      = 96,
    parameter int H_BP        = 48,
    parameter int V_ACTIVE    = 480,
    parameter int V_FP        = 10,
    parameter int V_SYNC      = 2,
    parameter int V_BP        = 33,
    parameter bit SYNC_POL    = 1'b0,
    parameter int PRIME_LEVEL = 512
) (
    input  logic                clk,
    input  logic                rst,
    input  logic                init_done,
    video_out_timing_if.master  fifo,
    output logic                hsync,
    output logic                vsync,
    output logic                de,
    output logic [15:0]         pix_data,
    output logic                frame_start,
    output logic                underflow
);
    localparam int H_TOTAL = H_ACTIVE + H_FP + H_SYNC + H_BP;
    localparam int V_TOTAL = V_ACTIVE + V_FP + V_SYNC + V_BP;
    localparam int HW = $clog2(H_TOTAL);
    localparam int VW = $clog2(V_TOTAL);

    localparam logic [HW-1:0] H_ACT_END  = HW'(H_ACTIVE);
    localparam logic [HW-1:0] H_SYNC_BEG = HW'(H_ACTIVE + H_FP);
    localparam logic [HW-1:0] H_SYNC_END = HW'(H_ACTIVE + H_FP + H_SYNC);
    localparam logic [HW-1:0] H_LAST     = HW'(H_TOTAL - 1);
    localparam logic [VW-1:0] V_ACT_END  = VW'(V_ACTIVE);
    localparam logic [VW-1:0] V_SYNC_BEG = VW'(V_ACTIVE + V_FP);
    localparam logic [VW-1:0] V_SYNC_END = VW'(V_ACTIVE + V_FP + V_SYNC);
    localparam logic [VW-1:0] V_LAST     = VW'(V_TOTAL - 1);
    localparam logic [9:0]    PRIME_CNT  = 10'(PRIME_LEVEL);

    typedef enum logic [1:0] {
        ST_IDLE,
        ST_PRIME,
        ST_RUN
    } state_t;

    state_t          state_q;
    state_t          state_d;
    logic [HW-1:0]   h_cnt;
    logic [VW-1:0]   v_cnt;
    logic            act;
    logic            hs0;
    logic            vs0;
    logic            popped_q;
    logic            rd_valid_q;

    always_ff @(posedge clk) begin
        if (rst) begin
            state_q <= ST_IDLE;
        end else begin
            state_q <= state_d;
        end
    end

    always_comb begin
        state_d = state_q;
        case (state_q)
            ST_IDLE:  if (init_done) state_d = ST_PRIME;
            ST_PRIME: if (fifo.fifo_rd_count >= PRIME_CNT) state_d = ST_RUN;
            ST_RUN:   state_d = ST_RUN;
            default:  state_d = ST_IDLE;
        endcase
        // Losing SDRAM init aborts from any state.
        if (!init_done) begin
            state_d = ST_IDLE;
        end
    end

    // Counters sit at zero outside RUN so the first RUN cycle is pixel (0,0).
    always_ff @(posedge clk) begin
        if (rst || state_d != ST_RUN) begin
            h_cnt <= '0;
            v_cnt <= '0;
        end else if (state_q == ST_RUN) begin
            if (h_cnt == H_LAST) begin
                h_cnt <= '0;
                v_cnt <= (v_cnt == V_LAST) ? '0 : v_cnt + 1'b1;
            end else begin
                h_cnt <= h_cnt + 1'b1;
            end
        end
    end

    assign act = (state_q == ST_RUN) && (h_cnt < H_ACT_END) && (v_cnt < V_ACT_END);
    assign hs0 = (state_q == ST_RUN) && (h_cnt >= H_SYNC_BEG) && (h_cnt < H_SYNC_END);
    assign vs0 = (state_q == ST_RUN) && (v_cnt >= V_SYNC_BEG) && (v_cnt < V_SYNC_END);

    assign fifo.rd_en    = act && !fifo.fifo_empty;
    assign fifo.rd_valid = rd_valid_q;

    always_ff @(posedge clk) begin
        if (rst) begin
            rd_valid_q <= 1'b0;
        end else begin
            rd_valid_q <= (state_d != ST_IDLE);
        end
    end

    // Stage-1 outputs drop to idle levels in the same cycle the FSM returns to IDLE.
    always_ff @(posedge clk) begin
        if (rst || !init_done) begin
            de          <= 1'b0;
            hsync       <= ~SYNC_POL;
            vsync       <= ~SYNC_POL;
            frame_start <= 1'b0;
            popped_q    <= 1'b0;
        end else begin
            de          <= act;
            hsync       <= hs0 ? SYNC_POL : ~SYNC_POL;
            vsync       <= vs0 ? SYNC_POL : ~SYNC_POL;
            frame_start <= act && (h_cnt == '0) && (v_cnt == '0);
            popped_q    <= fifo.rd_en;
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            underflow <= 1'b0;
        end else if (act && fifo.fifo_empty) begin
            underflow <= 1'b1;
        end
    end

    // FIFO data arrives the cycle after the pop, which is the cycle de shows that pixel.
    assign pix_data = (de && popped_q) ? fifo.fifo_dout : 16'h0000;

endmodule

// File: tb/tb_video_out_timing.sv
// Bench for video_out_timing on a reduced raster (15x8 total, 8x4 visible) with an emulated read FIFO.
module tb_video_out_timing;
    localparam int HA = 8;
    localparam int HFP = 2;
    localparam int HS = 3;
    localparam int HBP = 2;
    localparam int VA = 4;
    localparam int VFP = 1;
    localparam int VS = 2;
    localparam int VBP = 1;
    localparam int HT = HA + HFP + HS + HBP;
    localparam int VT = VA + VFP + VS + VBP;

    logic        clk = 1'b0;
    logic        rst;
    logic        init_done;
    logic        hsync;
    logic        vsync;
    logic        de;
    logic [15:0] pix_data;
    logic        frame_start;
    logic        underflow;

    video_out_timing_if fif ();

    video_out_timing #(
        .H_ACTIVE(HA), .H_FP(HFP), .H_SYNC(HS), .H_BP(HBP),
        .V_ACTIVE(VA), .V_FP(VFP), .V_SYNC(VS), .V_BP(VBP),
        .SYNC_POL(1'b0), .PRIME_LEVEL(512)
    ) dut (
        .clk(clk),
        .rst(rst),
        .init_done(init_done),
        .fifo(fif),
        .hsync(hsync),
        .vsync(vsync),
        .de(de),
        .pix_data(pix_data),
        .frame_start(frame_start),
        .underflow(underflow)
    );

    always #5 clk = ~clk;

    int n_cmp = 0;
    int n_bad = 0;

    task automatic chk(input string name, input logic [31:0] a, input logic [31:0] e);
        n_cmp++;
        if (a !== e) begin
            n_bad++;
            $display("FAIL %s: got 0x%0h expected 0x%0h at %0t", name, a, e, $time);
        end
    endtask

    // Read-FIFO emulation: a pop seen during a cycle presents the next word after the following edge.
    logic pop_seen = 1'b0;
    int   word = 0;
    always @(negedge clk) pop_seen <= fif.rd_en;
    always @(posedge clk) begin
        if (pop_seen) begin
            fif.fifo_dout <= 16'(word);
            word <= word + 1;
        end
    end

    // Reference model: raster position as a linear index since RUN entry, decoded with div/mod.
    function automatic bit in_act(input int k);
        return ((k % HT) < HA) && (((k / HT) % VT) < VA);
    endfunction

    bit mon_en = 1'b0;
    int m_mode = 0;
    int m_k = 0;
    int p_k = 0;
    int m_word = 0;
    int p_word = 0;
    bit p_stage = 1'b0;
    bit p_pop = 1'b0;
    bit m_uf = 1'b0;

    always @(negedge clk) begin : monitor
        int x, y, nm;
        bit p_act, act_now, e_rden, e_hs, e_vs, e_fs;
        logic [15:0] e_pix;
        if (mon_en) begin
            act_now = (m_mode == 2) && in_act(m_k);
            e_rden  = act_now && !fif.fifo_empty;
            x = p_k % HT;
            y = (p_k / HT) % VT;
            p_act = p_stage && in_act(p_k);
            e_hs  = !(p_stage && x >= HA + HFP && x < HA + HFP + HS);
            e_vs  = !(p_stage && y >= VA + VFP && y < VA + VFP + VS);
            e_fs  = p_stage && ((p_k % (HT * VT)) == 0);
            e_pix = (p_act && p_pop) ? 16'(p_word) : 16'h0000;

            chk("rd_valid", 32'(fif.rd_valid), 32'(m_mode != 0));
            chk("rd_en", 32'(fif.rd_en), 32'(e_rden));
            chk("de", 32'(de), 32'(p_act));
            chk("hsync", 32'(hsync), 32'(e_hs));
            chk("vsync", 32'(vsync), 32'(e_vs));
            chk("frame_start", 32'(frame_start), 32'(e_fs));
            chk("pix_data", 32'(pix_data), 32'(e_pix));
            chk("underflow", 32'(underflow), 32'(m_uf));

            if (rst) begin
                m_mode = 0; m_k = 0; p_stage = 0; p_pop = 0; m_uf = 0;
            end else begin
                if (act_now && fif.fifo_empty) m_uf = 1'b1;
                p_stage = (m_mode == 2) && init_done;
                p_k = m_k;
                p_pop = e_rden;
                if (e_rden) begin
                    p_word = m_word;
                    m_word++;
                end
                if (!init_done) nm = 0;
                else if (m_mode == 0) nm = 1;
                else if (m_mode == 1) nm = (fif.fifo_rd_count >= 10'd512) ? 2 : 1;
                else nm = 2;
                m_k = (m_mode == 2 && nm == 2) ? m_k + 1 : 0;
                m_mode = nm;
            end
        end
    end

    int n;
    int hs_lo, vs_lo, de_n, rd_n, fs_n, fs_gap;

    initial begin
        rst = 1'b1;
        init_done = 1'b0;
        fif.fifo_rd_count = 10'd0;
        fif.fifo_empty = 1'b0;
        @(posedge clk); #1 mon_en = 1'b1;
        repeat (2) @(posedge clk);
        @(negedge clk);
        chk("reset_rd_valid", 32'(fif.rd_valid), 0);
        chk("reset_hsync", 32'(hsync), 1);
        chk("reset_vsync", 32'(vsync), 1);
        chk("reset_de", 32'(de), 0);
        chk("reset_pix", 32'(pix_data), 0);
        chk("reset_underflow", 32'(underflow), 0);

        // Priming: one word short keeps the raster off.
        @(posedge clk); #1 rst = 1'b0; init_done = 1'b1; fif.fifo_rd_count = 10'd511;
        repeat (4) @(posedge clk);
        @(negedge clk);
        chk("prime_rd_valid", 32'(fif.rd_valid), 1);
        chk("prime_de", 32'(de), 0);
        chk("prime_rd_en", 32'(fif.rd_en), 0);

        @(posedge clk); #1 fif.fifo_rd_count = 10'd512;
        n = 0;
        @(negedge clk);
        while (!de && n < 10) begin n++; @(negedge clk); end
        chk("first_de_latency", 32'(n), 2);
        chk("first_frame_start", 32'(frame_start), 1);
        chk("first_pixel", 32'(pix_data), 32'h0000);

        // Two full frames with a FIFO that never runs dry.
        hs_lo = 0; vs_lo = 0; de_n = 0; rd_n = 0; fs_n = 0; fs_gap = 0;
        for (int i = 0; i < 2 * HT * VT; i++) begin
            if (i > 0) @(negedge clk);
            if (!hsync) hs_lo++;
            if (!vsync) vs_lo++;
            if (de) de_n++;
            if (fif.rd_en) rd_n++;
            if (frame_start) begin
                fs_n++;
                if (fs_n == 2) fs_gap = i;
            end
            if (i == 1) chk("second_pixel", 32'(pix_data), 32'h0001);
        end
        chk("hsync_low_cycles", 32'(hs_lo), 48);
        chk("vsync_low_cycles", 32'(vs_lo), 60);
        chk("de_cycles", 32'(de_n), 64);
        chk("rd_en_cycles", 32'(rd_n), 64);
        chk("frame_start_count", 32'(fs_n), 2);
        chk("frame_period", 32'(fs_gap), 120);

        // Starve three visible cycles early in a line.
        n = 0;
        do begin @(negedge clk); n++; end while (!frame_start && n < 300);
        chk("wait_frame_start", 32'(frame_start), 1);
        @(posedge clk); #1 fif.fifo_empty = 1'b1;
        @(negedge clk);
        chk("starve_rd_en_0", 32'(fif.rd_en), 0);
        for (int i = 0; i < 2; i++) begin
            @(negedge clk);
            chk("starve_rd_en", 32'(fif.rd_en), 0);
            chk("starve_pix", 32'(pix_data), 0);
            chk("starve_de", 32'(de), 1);
            chk("starve_underflow", 32'(underflow), 1);
        end
        @(posedge clk); #1 fif.fifo_empty = 1'b0;
        @(negedge clk);
        chk("starve_last_pix", 32'(pix_data), 0);
        chk("starve_last_de", 32'(de), 1);
        chk("resume_rd_en", 32'(fif.rd_en), 1);
        repeat (30) @(negedge clk);
        chk("underflow_sticky", 32'(underflow), 1);

        // Drop init mid-line, then re-prime and restart.
        n = 0;
        do begin @(negedge clk); n++; end while (!(de && fif.rd_en) && n < 300);
        chk("wait_mid_line", 32'(de), 1);
        @(posedge clk); #1 init_done = 1'b0;
        @(negedge clk);
        chk("drop_still_valid", 32'(fif.rd_valid), 1);
        @(posedge clk); #1 init_done = 1'b1; fif.fifo_rd_count = 10'd100;
        @(negedge clk);
        chk("drop_de", 32'(de), 0);
        chk("drop_rd_valid", 32'(fif.rd_valid), 0);
        chk("drop_hsync", 32'(hsync), 1);
        chk("drop_pix", 32'(pix_data), 0);
        @(negedge clk);
        chk("reprime_rd_valid", 32'(fif.rd_valid), 1);
        chk("reprime_de", 32'(de), 0);
        repeat (3) @(posedge clk);
        #1 fif.fifo_rd_count = 10'd600;
        n = 0;
        @(negedge clk);
        while (!de && n < 10) begin n++; @(negedge clk); end
        chk("restart_de_latency", 32'(n), 2);
        chk("restart_frame_start", 32'(frame_start), 1);
        repeat (130) @(negedge clk);

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
        $finish;
    end
endmodule
